spi_slave_rx: RTL and testbench

//  Serial front end of the SPI slave. handshake raises start; this block then

---
 rtl/spi_slave_rx.sv | 183 ++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI mode-0 slave frame receiver with response shifter
// Pins are synchronised to clk, edge-detected, and one frame is captured per start.
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_W - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DATA_W);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic [DATA_W-1:0] r_tx_sr;
    logic [DATA_W-1:0] r_rx_sr;
    logic [DATA_W-1:0] r_rx_data;
    logic [CW-1:0]     r_bit_cnt;
    logic [TW-1:0]     r_tcnt;
    logic              r_done;
    logic              r_err;

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_abort;
    logic w_timeout;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;

    // Synchronisers reset to the bus idle levels so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A rise that completes the frame wins over a simultaneous deselect.
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!w_cs_s) begin
                    w_state_nxt = S_SHIFT;
                end else if (r_tcnt == TMO_LIMIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_sclk_rise && (r_bit_cnt == LAST_BIT)) begin
                    w_state_nxt = S_DONE;
                end else if (w_cs_rise) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
            r_bit_cnt <= '0;
            r_tcnt    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_abort | w_timeout;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tcnt <= '0;
                    end
                end
                S_ARMED: begin
                    if (!w_cs_s) begin
                        r_tx_sr   <= tx_data;
                        r_rx_sr   <= '0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_sclk_rise) begin
                        r_rx_sr   <= {r_rx_sr[DATA_W-2:0], w_mosi_s};
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                    end
                    if (w_sclk_fall && (r_bit_cnt < FULL_CNT)) begin
                        r_tx_sr <= r_tx_sr << 1;
                    end
                end
                S_DONE: begin
                    r_rx_data <= r_rx_sr;
                    r_done    <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign miso    = (r_state == S_SHIFT) && !w_cs_s ? r_tx_sr[DATA_W-1] : 1'b0;
    assign rx_data = r_rx_data;
    assign done    = r_done;
    assign err     = r_err;
    assign busy    = (r_state == S_ARMED) || (r_state == S_SHIFT);

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - self-checking bench for spi_slave_rx
// Table of frames plus hand-written timeout and reset sequences.
module tb_spi_slave_rx;

    localparam int DW   = 8;
    localparam int TC   = 16;
    localparam int SS   = 2;
    localparam int HALF = 4;
    localparam int NV   = 10;

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] mw;
        int            nbits;
        bit            extra;
        bit            smid;
        logic [DW-1:0] exp_rx;
        logic [DW-1:0] exp_mo;
        int            exp_done;
        int            exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, start, sclk, cs_n, mosi;
    logic          miso, done, busy, err;
    logic [DW-1:0] tx_data, rx_data;

    int   n_checks = 0, n_fail = 0;
    int   cyc = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0, dbl_done = 0;
    int   rise_cyc = 0, start_cyc = 0;
    logic prev_done = 1'b0;
    vec_t vt[NV];

    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_W(DW), .TIMEOUT_CYC(TC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .start(start), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso), .tx_data(tx_data), .rx_data(rx_data),
        .done(done), .busy(busy), .err(err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_done <= done;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (done && prev_done) dbl_done <= dbl_done + 1;
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [DW-1:0] tx);
        @(negedge clk);
        start   = 1'b1;
        tx_data = tx;
        @(negedge clk);
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic run_frame(input logic [DW-1:0] mw, input int nbits, input bit extra,
                             input bit smid, output logic [DW-1:0] mo);
        mo = '0;
        @(negedge clk);
        cs_n = 1'b0;
        mosi = mw[DW-1];
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mo[DW-1-i] = miso;
            sclk = 1'b1;
            if (i == DW-1) rise_cyc = cyc;
            if (smid && i == 3) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (HALF-1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sclk = 1'b0;
            if (i < DW-1) mosi = mw[DW-2-i];
            repeat (HALF) @(negedge clk);
        end
        if (extra) begin
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] last_rx, mo;
        int dc0, ec0, got, lat;

        rst = 1'b1; start = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_miso", miso, 0);
        check("reset_rx", rx_data, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);

        vt[0] = '{tx: 8'h3C, mw: 8'hA5, nbits: 8, extra: 0, smid: 0, default: 0};
        vt[1] = '{tx: 8'h96, mw: 8'h33, nbits: 4, extra: 0, smid: 0, default: 0};
        vt[2] = '{tx: 8'h3C, mw: 8'hA5, nbits: 8, extra: 1, smid: 1, default: 0};
        vt[3] = '{tx: 8'h81, mw: 8'h01, nbits: 8, extra: 0, smid: 0, default: 0};
        vt[4] = '{tx: 8'h7E, mw: 8'hFE, nbits: 8, extra: 0, smid: 0, default: 0};
        for (int k = 5; k < NV; k++) begin
            vt[k].tx    = DW'($urandom);
            vt[k].mw    = DW'($urandom);
            vt[k].nbits = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DW-1)) : DW;
            vt[k].extra = 1'($urandom_range(0, 1));
            vt[k].smid  = 1'($urandom_range(0, 1));
        end
        last_rx = '0;
        for (int k = 0; k < NV; k++) begin
            vt[k].exp_done = (vt[k].nbits == DW) ? 1 : 0;
            vt[k].exp_err  = 1 - vt[k].exp_done;
            vt[k].exp_rx   = (vt[k].nbits == DW) ? vt[k].mw : last_rx;
            vt[k].exp_mo   = vt[k].tx & ~(DW'({DW{1'b1}}) >> vt[k].nbits);
            last_rx        = vt[k].exp_rx;
        end

        for (int k = 0; k < NV; k++) begin
            if (vt[k].nbits < DW) vt[k].extra = 0;
            dc0 = done_cnt;
            ec0 = err_cnt;
            do_start(vt[k].tx);
            check($sformatf("v%0d_busy_armed", k), busy, 1);
            run_frame(vt[k].mw, vt[k].nbits, vt[k].extra, vt[k].smid, mo);
            check($sformatf("v%0d_rx", k), rx_data, vt[k].exp_rx);
            check($sformatf("v%0d_done", k), done_cnt - dc0, vt[k].exp_done);
            check($sformatf("v%0d_err", k), err_cnt - ec0, vt[k].exp_err);
            check($sformatf("v%0d_miso", k), mo, vt[k].exp_mo);
            check($sformatf("v%0d_idle", k), {busy, miso}, 0);
            if (vt[k].exp_done == 1)
                check($sformatf("v%0d_latency", k), done_cyc - rise_cyc, SS + 2);
        end

        // arm timeout with cs_n held high
        dc0 = done_cnt;
        ec0 = err_cnt;
        do_start(8'h00);
        got = 0;
        lat = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            @(negedge clk);
            if (err) begin
                got = 1;
                lat = cyc - start_cyc;
            end
        end
        check("tmo_seen", got, 1);
        check("tmo_cycle", lat, TC);
        repeat (2) @(negedge clk);
        check("tmo_busy", busy, 0);
        check("tmo_done", done_cnt - dc0, 0);
        check("tmo_err_once", err_cnt - ec0, 1);

        // reset in the middle of a frame
        dc0 = done_cnt;
        do_start(8'hC3);
        @(negedge clk);
        cs_n = 1'b0;
        mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            mosi = ~mosi;
            repeat (HALF) @(negedge clk);
            if (i == 4) begin
                check("rst_busy_before", busy, 1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_outs", {miso, done, busy, err}, 0);
                check("rst_rx", rx_data, 0);
            end
        end
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_no_done", done_cnt - dc0, 0);
        check("rst_idle", busy, 0);
        do_start(8'h0F);
        run_frame(8'h5A, DW, 1'b0, 1'b0, mo);
        check("rst_next_rx", rx_data, 8'h5A);
        check("rst_next_done", done_cnt - dc0, 1);
        check("rst_next_miso", mo, 8'h0F);

        check("done_single_cycle", dbl_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
